echo_indication_output: RTL



---
 rtl/echo_portal_pkg.sv | 28 ++
 rtl/echo_ind_fifo.sv | 44 ++++
 rtl/echo_indication_output.sv | 76 +++++++
 3 files changed

// File: rtl/echo_portal_pkg.sv
// echo_portal_pkg: shared portal header layout, FSM encoding and message constants
package echo_portal_pkg;

    typedef enum logic {
        HDR = 1'b0,
        PAY = 1'b1
    } state_t;

    localparam int ECHO_MSG_WORDS = 2;

    localparam int HDR_PORTAL_MSB = 31;
    localparam int HDR_PORTAL_LSB = 16;
    localparam int HDR_METHOD_MSB = 15;
    localparam int HDR_METHOD_LSB = 8;
    localparam int HDR_LEN_MSB    = 7;
    localparam int HDR_LEN_LSB    = 0;

    // Length counts every word of the message, header included.
    function automatic logic [31:0] make_hdr(input logic [15:0] portal, input logic [7:0] method);
        logic [31:0] h;
        h = '0;
        h[HDR_PORTAL_MSB:HDR_PORTAL_LSB] = portal;
        h[HDR_METHOD_MSB:HDR_METHOD_LSB] = method;
        h[HDR_LEN_MSB:HDR_LEN_LSB]       = 8'(ECHO_MSG_WORDS);
        return h;
    endfunction

endpackage

// File: rtl/echo_ind_fifo.sv
// echo_ind_fifo: power-of-two FIFO of indication values; pointers carry one extra wrap bit.
module echo_ind_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enq,
    input  logic [31:0] enq_data,
    input  logic        deq,
    output logic        full,
    output logic        empty,
    output logic [31:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] WRAP = {1'b1, {AW{1'b0}}};

    logic [31:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q[AW-1:0]] <= enq_data;
    end

    assign full  = (wr_ptr_q ^ rd_ptr_q) == WRAP;
    assign empty = wr_ptr_q == rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/echo_indication_output.sv
// echo_indication_output: serializes heard indications into header+payload portal words,
// buffered by a small FIFO, with a running count of completed messages.
module echo_indication_output
    import echo_portal_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] PORTAL_ID = 16'd5,
    parameter logic [7:0]  METHOD_ID = 8'd0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        heard__ENA,
    input  logic [31:0] heard_heard_v,
    output logic        heard__RDY,
    output logic        pipe_enq__ENA,
    output logic [31:0] pipe_enq_v,
    input  logic        pipe_enq__RDY,
    output logic [31:0] msg_count
);
    state_t      state_q, state_d;
    logic [31:0] msg_count_q, msg_count_d;
    logic        rdy_en_q, rdy_en_d;
    logic        fifo_full, fifo_empty, fifo_deq, fifo_enq;
    logic [31:0] fifo_head;

    // Holds ready low while in reset and releases it on the first edge afterwards.
    assign rdy_en_d   = 1'b1;
    assign heard__RDY = rdy_en_q && !fifo_full;
    assign fifo_enq   = heard__ENA && heard__RDY;

    echo_ind_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (CLK),
        .rst_n    (nRST),
        .enq      (fifo_enq),
        .enq_data (heard_heard_v),
        .deq      (fifo_deq),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    always_comb begin
        state_d       = state_q;
        msg_count_d   = msg_count_q;
        fifo_deq      = 1'b0;
        pipe_enq__ENA = 1'b0;
        pipe_enq_v    = '0;
        if (!fifo_empty && pipe_enq__RDY) begin
            pipe_enq__ENA = 1'b1;
            if (state_q == HDR) begin
                pipe_enq_v = make_hdr(PORTAL_ID, METHOD_ID);
                state_d    = PAY;
            end else begin
                pipe_enq_v  = fifo_head;
                fifo_deq    = 1'b1;
                msg_count_d = msg_count_q + 32'd1;
                state_d     = HDR;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= HDR;
            msg_count_q <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_count_q <= msg_count_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

    assign msg_count = msg_count_q;

endmodule
